// File: rtl/binarization_threshold_ctrl_pkg.sv
// Shared image-pipeline definitions for the binarization threshold controller:
// gray width, the power-on threshold and the control state encodings.
package binarization_threshold_ctrl_pkg;

  localparam int GRAY_W = 8;
  localparam logic [GRAY_W-1:0] DEFAULT_THRESH = 8'd128;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DIV  = 2'd1,
    LOAD = 2'd2
  } ctrl_state_t;

  // Where the next published threshold comes from, fixed at frame end.
  typedef enum logic [1:0] {
    SRC_MANUAL  = 2'd0,
    SRC_DEFAULT = 2'd1,
    SRC_MEAN    = 2'd2
  } thr_src_t;

endpackage

// File: rtl/binarization_threshold_ctrl_serial_divider.sv
// Serial restoring divider: one quotient bit per cycle, DVD_W cycles after start.
// done is high during the final iteration cycle; quotient is final on the following cycle.
module binarization_threshold_ctrl_serial_divider #(
  parameter int DVD_W = 28,
  parameter int DVS_W = 20
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [DVD_W-1:0] dividend,
  input  logic [DVS_W-1:0] divisor,
  output logic [DVD_W-1:0] quotient,
  output logic             busy,
  output logic             done
);

  localparam int CNT_W = $clog2(DVD_W);
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(DVD_W - 1);

  logic [CNT_W-1:0] step_cnt;
  logic [DVS_W-1:0] divisor_p0;
  logic [DVS_W:0]   rem_p0;
  logic [DVS_W:0]   rem_shift;
  logic [DVS_W:0]   rem_sub;
  logic             fits;

  // The dividend shifts out of the quotient register MSB-first while quotient bits shift in.
  always_comb begin
    rem_shift = {rem_p0[DVS_W-1:0], quotient[DVD_W-1]};
    rem_sub   = rem_shift - {1'b0, divisor_p0};
    fits      = (rem_shift >= {1'b0, divisor_p0});
  end

  assign done = busy && (step_cnt == LAST_STEP);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy     <= 1'b0;
      step_cnt <= '0;
    end else if (start) begin
      busy     <= 1'b1;
      step_cnt <= '0;
    end else if (busy) begin
      step_cnt <= step_cnt + 1'b1;
      if (done) begin
        busy <= 1'b0;
      end
    end
  end

  // stage p0: operand capture / iteration
  always_ff @(posedge clk) begin
    if (start) begin
      rem_p0     <= '0;
      quotient   <= dividend;
      divisor_p0 <= divisor;
    end else if (busy) begin
      rem_p0   <= fits ? rem_sub : rem_shift;
      quotient <= {quotient[DVD_W-2:0], fits};
    end
  end

endmodule

// File: rtl/binarization_threshold_ctrl.sv
// Frame-synchronous binarization threshold: frame mean plus offset (auto) or a register
// value (manual), published only at frame boundaries so a frame never sees two thresholds.
module binarization_threshold_ctrl #(
  parameter int         PIX_CNT_W      = 20,
  parameter logic [7:0] DEFAULT_THRESH = binarization_threshold_ctrl_pkg::DEFAULT_THRESH,
  parameter int         SUM_W          = PIX_CNT_W + 8
) (
  input  logic                                         clk,
  input  logic                                         rst_n,
  input  logic                                         gray_vsync,
  input  logic                                         gray_clken,
  input  logic                                         gray_data_valid,
  input  logic [binarization_threshold_ctrl_pkg::GRAY_W-1:0] luminance,
  input  logic                                         cfg_auto,
  input  logic [binarization_threshold_ctrl_pkg::GRAY_W-1:0] cfg_threshold,
  input  logic signed [binarization_threshold_ctrl_pkg::GRAY_W-1:0] cfg_offset,
  output logic [binarization_threshold_ctrl_pkg::GRAY_W-1:0] threshold,
  output logic                                         threshold_upd,
  output logic                                         busy,
  output logic                                         frame_dropped
);

  import binarization_threshold_ctrl_pkg::*;

  localparam logic [PIX_CNT_W-1:0] CNT_MAX = '1;

  function automatic logic [GRAY_W-1:0] sat_gray(input logic [SUM_W-1:0] q);
    return (q > SUM_W'(255)) ? 8'hFF : q[GRAY_W-1:0];
  endfunction

  function automatic logic [GRAY_W-1:0] add_offset_sat(input logic [GRAY_W-1:0] base,
                                                       input logic signed [GRAY_W-1:0] off);
    logic signed [GRAY_W+1:0] s;
    s = $signed({2'b00, base}) + $signed({{2{off[GRAY_W-1]}}, off});
    if (s < 0)                 return '0;
    else if (s > 10'sd255)     return 8'hFF;
    else                       return s[GRAY_W-1:0];
  endfunction

  logic                 vsync_p0;
  logic                 frame_end;
  logic                 accept;
  logic [SUM_W-1:0]     sum_acc;
  logic [PIX_CNT_W-1:0] cnt_acc;
  ctrl_state_t          state;
  ctrl_state_t          state_next;
  thr_src_t             src_p0;
  logic                 div_start;
  logic                 div_done;
  logic                 div_busy;
  logic [SUM_W-1:0]     quotient;
  logic [GRAY_W-1:0]    load_value;

  assign frame_end = gray_vsync & ~vsync_p0;
  assign accept    = gray_clken & gray_data_valid;
  assign div_start = frame_end && (state == IDLE) && cfg_auto && (cnt_acc != '0);
  assign busy      = div_busy;

  // stage p0: vsync edge detector
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vsync_p0 <= 1'b0;
    end else begin
      vsync_p0 <= gray_vsync;
    end
  end

  // A pixel accepted in the frame-end cycle opens the new frame's accumulation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_acc <= '0;
      cnt_acc <= '0;
    end else if (frame_end) begin
      sum_acc <= accept ? SUM_W'(luminance) : '0;
      cnt_acc <= accept ? PIX_CNT_W'(1) : '0;
    end else if (accept) begin
      sum_acc <= sum_acc + SUM_W'(luminance);
      if (cnt_acc != CNT_MAX) begin
        cnt_acc <= cnt_acc + 1'b1;
      end
    end
  end

  binarization_threshold_ctrl_serial_divider #(
    .DVD_W (SUM_W),
    .DVS_W (PIX_CNT_W)
  ) u_divider (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (div_start),
    .dividend (sum_acc),
    .divisor  (cnt_acc),
    .quotient (quotient),
    .busy     (div_busy),
    .done     (div_done)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      src_p0 <= SRC_DEFAULT;
    end else begin
      state <= state_next;
      if (frame_end && (state == IDLE)) begin
        if (!cfg_auto)             src_p0 <= SRC_MANUAL;
        else if (cnt_acc == '0)    src_p0 <= SRC_DEFAULT;
        else                       src_p0 <= SRC_MEAN;
      end
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (frame_end) state_next = (cfg_auto && (cnt_acc != '0)) ? DIV : LOAD;
      DIV:     if (div_done)  state_next = LOAD;
      LOAD:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Manual threshold and offset are taken live in the LOAD cycle.
  always_comb begin
    load_value = DEFAULT_THRESH;
    case (src_p0)
      SRC_MANUAL:  load_value = cfg_threshold;
      SRC_DEFAULT: load_value = DEFAULT_THRESH;
      SRC_MEAN:    load_value = add_offset_sat(sat_gray(quotient), cfg_offset);
      default:     load_value = DEFAULT_THRESH;
    endcase
  end

  // stage p1: published threshold
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      threshold     <= DEFAULT_THRESH;
      threshold_upd <= 1'b0;
      frame_dropped <= 1'b0;
    end else begin
      threshold_upd <= (state == LOAD);
      if (state == LOAD) begin
        threshold <= load_value;
      end
      if (frame_end && (state != IDLE)) begin
        frame_dropped <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_binarization_threshold_ctrl.sv
// Self-checking bench: directed frames with literal expectations plus randomized frames
// compared every cycle against a frame-level arithmetic model.
`timescale 1ns/1ps
module tb_binarization_threshold_ctrl;

  localparam int SUM_W   = 28;
  localparam int CNT_MAX = (1 << 20) - 1;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       gray_vsync = 1'b0;
  logic       gray_clken = 1'b0;
  logic       gray_data_valid = 1'b0;
  logic [7:0] luminance = '0;
  logic       cfg_auto = 1'b0;
  logic [7:0] cfg_threshold = '0;
  logic [7:0] cfg_offset = '0;
  logic [7:0] threshold;
  logic       threshold_upd;
  logic       busy;
  logic       frame_dropped;

  always #5 clk = ~clk;

  binarization_threshold_ctrl dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .gray_vsync      (gray_vsync),
    .gray_clken      (gray_clken),
    .gray_data_valid (gray_data_valid),
    .luminance       (luminance),
    .cfg_auto        (cfg_auto),
    .cfg_threshold   (cfg_threshold),
    .cfg_offset      (cfg_offset),
    .threshold       (threshold),
    .threshold_upd   (threshold_upd),
    .busy            (busy),
    .frame_dropped   (frame_dropped)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic int add_off(input int base, input logic [7:0] off);
    int r;
    r = base + int'($signed(off));
    if (r < 0)   r = 0;
    if (r > 255) r = 255;
    return r;
  endfunction

  function automatic int mean_sat(input longint s, input int c);
    longint q;
    q = s / c;
    return (q > 255) ? 255 : int'(q);
  endfunction

  // Frame-level model: edge index e, pending load scheduled at an absolute edge.
  int         e, m_cnt, m_load_e, m_div_e, m_kind, m_mean;
  longint     m_sum;
  logic       m_vs, m_pend, m_upd, m_busy, m_drop;
  logic [7:0] m_thr;
  logic       fe_w, acc_w;

  assign fe_w  = gray_vsync & ~m_vs;
  assign acc_w = gray_clken & gray_data_valid;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e <= 0; m_vs <= 1'b0; m_sum <= 0; m_cnt <= 0; m_pend <= 1'b0;
      m_load_e <= 0; m_div_e <= 0; m_kind <= 0; m_mean <= 0;
      m_thr <= 8'd128; m_upd <= 1'b0; m_busy <= 1'b0; m_drop <= 1'b0;
    end else begin
      e     <= e + 1;
      m_vs  <= gray_vsync;
      m_upd <= 1'b0;
      m_busy <= m_pend && (e + 1 < m_div_e);
      if (m_pend && (e + 1 == m_load_e)) begin
        m_upd  <= 1'b1;
        m_pend <= 1'b0;
        m_thr  <= (m_kind == 0) ? cfg_threshold :
                  (m_kind == 1) ? 8'd128 : 8'(add_off(m_mean, cfg_offset));
      end
      if (fe_w) begin
        m_sum <= acc_w ? longint'(luminance) : 0;
        m_cnt <= acc_w ? 1 : 0;
        if (m_pend) begin
          m_drop <= 1'b1;
        end else begin
          m_pend <= 1'b1;
          if (!cfg_auto) begin
            m_kind <= 0; m_load_e <= e + 2; m_div_e <= 0;
          end else if (m_cnt == 0) begin
            m_kind <= 1; m_load_e <= e + 2; m_div_e <= 0;
          end else begin
            m_kind <= 2; m_mean <= mean_sat(m_sum, m_cnt);
            m_load_e <= e + SUM_W + 2; m_div_e <= e + SUM_W + 1; m_busy <= 1'b1;
          end
        end
      end else if (acc_w) begin
        m_sum <= m_sum + longint'(luminance);
        m_cnt <= (m_cnt < CNT_MAX) ? m_cnt + 1 : m_cnt;
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      n_cmp++;
      if (threshold !== m_thr || threshold_upd !== m_upd || busy !== m_busy ||
          frame_dropped !== m_drop) begin
        n_bad++;
        if (n_bad <= 20)
          $display("FAIL model t=%0t: thr %0d/%0d upd %b/%b busy %b/%b drop %b/%b (got/expected)",
                   $time, threshold, m_thr, threshold_upd, m_upd, busy, m_busy,
                   frame_dropped, m_drop);
      end
    end
  end

  task automatic pix(input int v);
    @(posedge clk); #1;
    gray_clken = 1'b1; gray_data_valid = 1'b1; luminance = 8'(v);
  endtask

  task automatic frame_end_check(input string nm, input int exp_lat, input int exp_val);
    int lat;
    int got;
    @(posedge clk); #1;
    gray_clken = 1'b0; gray_data_valid = 1'b0; gray_vsync = 1'b1;
    lat = 0; got = 0;
    while (got == 0 && lat < 80) begin
      @(posedge clk); #1;
      lat++;
      if (lat == 3) gray_vsync = 1'b0;
      @(negedge clk);
      if (threshold_upd) got = 1;
    end
    check({nm, "_seen"}, got, 1);
    check({nm, "_lat"}, lat, exp_lat);
    check({nm, "_val"}, int'(threshold), exp_val);
    @(posedge clk); #1; gray_vsync = 1'b0;
    @(negedge clk);
    check({nm, "_upd_once"}, int'(threshold_upd), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int first_lat, n_upd, npix, vh, gap;

    repeat (3) @(negedge clk);
    check("rst_thr", int'(threshold), 128);
    check("rst_upd", int'(threshold_upd), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_drop", int'(frame_dropped), 0);
    @(posedge clk); #1; rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_thr", int'(threshold), 128);
    check("post_rst_busy", int'(busy), 0);

    cfg_auto = 1'b0; cfg_threshold = 8'd77;
    for (int i = 0; i < 5; i++) pix(i * 7);
    @(negedge clk);
    check("manual_hold_a", int'(threshold), 128);
    cfg_threshold = 8'd90;
    for (int i = 0; i < 5; i++) pix(200 - i);
    @(negedge clk);
    check("manual_hold_b", int'(threshold), 128);
    frame_end_check("manual", 2, 90);

    cfg_auto = 1'b1; cfg_offset = 8'd0;
    pix(10); pix(20); pix(30); pix(40);
    frame_end_check("auto_mean", 30, 25);

    cfg_offset = 8'd20;
    for (int i = 0; i < 6; i++) pix(250);
    frame_end_check("sat_high", 30, 255);

    cfg_offset = 8'hEC;
    for (int i = 0; i < 3; i++) pix(5);
    frame_end_check("sat_low", 30, 0);

    frame_end_check("zero_pix", 2, 128);

    cfg_offset = 8'd0;
    pix(100); pix(200);
    @(posedge clk); #1;
    gray_clken = 1'b0; gray_data_valid = 1'b0; gray_vsync = 1'b1;
    first_lat = 0; n_upd = 0;
    for (int i = 1; i <= 45; i++) begin
      @(posedge clk); #1;
      if (i == 3)  gray_vsync = 1'b0;
      if (i == 10) gray_vsync = 1'b1;
      if (i == 13) gray_vsync = 1'b0;
      gray_clken = (i >= 4 && i <= 8); gray_data_valid = (i >= 4 && i <= 8);
      luminance = 8'd255;
      @(negedge clk);
      if (threshold_upd) begin
        n_upd++;
        if (first_lat == 0) first_lat = i;
      end
    end
    check("b2b_lat", first_lat, 30);
    check("b2b_upd_count", n_upd, 1);
    check("b2b_val", int'(threshold), 150);
    check("b2b_dropped", int'(frame_dropped), 1);
    pix(60); pix(70); pix(80);
    frame_end_check("after_drop", 30, 70);
    check("drop_sticky", int'(frame_dropped), 1);

    pix(50); pix(60);
    @(posedge clk); #1;
    gray_clken = 1'b0; gray_data_valid = 1'b0; gray_vsync = 1'b1;
    repeat (10) @(posedge clk);
    #1; gray_vsync = 1'b0;
    #1; rst_n = 1'b0;
    #1;
    check("arst_thr", int'(threshold), 128);
    check("arst_busy", int'(busy), 0);
    check("arst_upd", int'(threshold_upd), 0);
    check("arst_drop", int'(frame_dropped), 0);
    repeat (3) @(posedge clk);
    #1; rst_n = 1'b1;

    for (int f = 0; f < 50; f++) begin
      cfg_auto = ($urandom_range(0, 3) != 0);
      cfg_offset = 8'($urandom);
      cfg_threshold = 8'($urandom);
      npix = $urandom_range(0, 24);
      for (int p = 0; p < npix; p++) begin
        @(posedge clk); #1;
        gray_clken = ($urandom_range(0, 7) != 0);
        gray_data_valid = ($urandom_range(0, 7) != 0);
        luminance = 8'($urandom);
        if ($urandom_range(0, 15) == 0) cfg_threshold = 8'($urandom);
        if ($urandom_range(0, 15) == 0) cfg_offset = 8'($urandom);
      end
      @(posedge clk); #1;
      gray_vsync = 1'b1; gray_clken = 1'($urandom_range(0, 1)); gray_data_valid = 1'b1;
      luminance = 8'($urandom);
      vh = $urandom_range(1, 3);
      repeat (vh) begin
        @(posedge clk); #1;
        gray_clken = 1'b0; gray_data_valid = 1'b0;
      end
      gray_vsync = 1'b0;
      gap = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 20) : $urandom_range(30, 45);
      repeat (gap) begin
        @(posedge clk); #1;
        if ($urandom_range(0, 15) == 0) cfg_offset = 8'($urandom);
        if ($urandom_range(0, 15) == 0) cfg_auto = ~cfg_auto;
      end
    end
    repeat (40) @(posedge clk);
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
